regfile_port_arbiter: RTL and testbench

Arbiter and sequencer for the single-port, 32-entry register-file SRAM. Each cycle it accepts at most one of three requesters: two read ports (rs1, rs2, from decode) and one write port (writeback). It drives the SRAM's `we`/`addr`/`din` and returns registered read data with a valid pulse. Writes have priority over reads. A bounded starvation counter guarantees read progress, and a round-robin pointer keeps the two read ports fair.

---
 rtl/regfile_port_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// Single-port register-file SRAM arbiter: write-priority with bounded read starvation and rs1/rs2 round-robin.
// Optional macro REGFILE_X0_ZERO_EN hardwires address 0 to zero.
module regfile_port_arbiter #(
   parameter int ADDR_WIDTH   = 5,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rs1_req,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   output logic                  rs1_gnt,
   output logic                  rs1_valid,
   output logic [DATA_WIDTH-1:0] rs1_data,
   input  logic                  rs2_req,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   output logic                  rs2_gnt,
   output logic                  rs2_valid,
   output logic [DATA_WIDTH-1:0] rs2_data,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_gnt,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic          rr_ptr_q, rr_ptr_d;
   logic [CW-1:0] starve_cnt_q, starve_cnt_d;
   logic [1:0]    pend_q, pend_d;
   logic [DATA_WIDTH-1:0] hold1_q, hold1_d, hold2_q, hold2_d;
   logic [DATA_WIDTH-1:0] rd1_val, rd2_val;
   logic          any_rd;
   logic          wr_commit;

   // Grants are gated by reset so nothing reaches the SRAM while rst is high
   always_comb begin
      any_rd  = rs1_req | rs2_req;
      wr_gnt  = 1'b0;
      rs1_gnt = 1'b0;
      rs2_gnt = 1'b0;
      if (!rst) begin
         if (wr_req && (!any_rd || starve_cnt_q != LIMIT)) begin
            wr_gnt = 1'b1;
         end else if (rs1_req && (!rs2_req || !rr_ptr_q)) begin
            rs1_gnt = 1'b1;
         end else if (rs2_req) begin
            rs2_gnt = 1'b1;
         end
      end
   end

`ifdef REGFILE_X0_ZERO_EN
   logic [1:0] zero_q, zero_d;

   always_comb begin
      wr_commit = wr_gnt && (wr_addr != '0);
      zero_d    = {rs2_gnt && (rs2_addr == '0), rs1_gnt && (rs1_addr == '0)};
      rd1_val   = zero_q[0] ? '0 : sram_dout;
      rd2_val   = zero_q[1] ? '0 : sram_dout;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) zero_q <= '0;
      else     zero_q <= zero_d;
   end
`else
   always_comb begin
      wr_commit = wr_gnt;
      rd1_val   = sram_dout;
      rd2_val   = sram_dout;
   end
`endif

   always_comb begin
      sram_we   = 1'b0;
      sram_addr = '0;
      sram_din  = '0;
      if (wr_gnt) begin
         sram_we   = wr_commit;
         sram_addr = wr_addr;
         sram_din  = wr_data;
      end else if (rs1_gnt) begin
         sram_addr = rs1_addr;
      end else if (rs2_gnt) begin
         sram_addr = rs2_addr;
      end
   end

   always_comb begin
      rs1_valid = pend_q[0];
      rs2_valid = pend_q[1];
      rs1_data  = rs1_valid ? rd1_val : hold1_q;
      rs2_data  = rs2_valid ? rd2_val : hold2_q;
   end

   // Pointer names the port that did not win last; counter only tracks writes that block a waiting read
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (rs1_gnt)      rr_ptr_d = 1'b1;
      else if (rs2_gnt) rr_ptr_d = 1'b0;

      starve_cnt_d = starve_cnt_q;
      if (!any_rd || rs1_gnt || rs2_gnt)     starve_cnt_d = '0;
      else if (wr_gnt && starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + CW'(1);

      pend_d  = {rs2_gnt, rs1_gnt};
      hold1_d = rs1_valid ? rs1_data : hold1_q;
      hold2_d = rs2_valid ? rs2_data : hold2_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q     <= 1'b0;
         starve_cnt_q <= '0;
         pend_q       <= '0;
         hold1_q      <= '0;
         hold2_q      <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         starve_cnt_q <= starve_cnt_d;
         pend_q       <= pend_d;
         hold1_q      <= hold1_d;
         hold2_q      <= hold2_d;
      end
   end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Table-driven bench for regfile_port_arbiter with an SRAM model and a read-response scoreboard.
module tb_regfile_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rs1_req, rs2_req, wr_req;
   logic [4:0]  rs1_addr, rs2_addr, wr_addr;
   logic [31:0] wr_data;
   logic        rs1_gnt, rs2_gnt, wr_gnt, rs1_valid, rs2_valid;
   logic [31:0] rs1_data, rs2_data;
   logic        sram_we;
   logic [4:0]  sram_addr;
   logic [31:0] sram_din, sram_dout;

   always #5 clk = ~clk;

   regfile_port_arbiter dut (
      .clk(clk), .rst(rst),
      .rs1_req(rs1_req), .rs1_addr(rs1_addr), .rs1_gnt(rs1_gnt), .rs1_valid(rs1_valid), .rs1_data(rs1_data),
      .rs2_req(rs2_req), .rs2_addr(rs2_addr), .rs2_gnt(rs2_gnt), .rs2_valid(rs2_valid), .rs2_data(rs2_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
   );

   // Registered-read SRAM; the preload port lets the bench fill it without the DUT
   logic        pre_we;
   logic [4:0]  pre_addr;
   logic [31:0] pre_data;
   logic [31:0] mem [32];

   always @(posedge clk) begin
      if (pre_we)       mem[pre_addr]  <= pre_data;
      else if (sram_we) mem[sram_addr] <= sram_din;
      sram_dout <= mem[sram_addr];
   end

   typedef struct {
      logic        r1, r2, w;
      logic [4:0]  a1, a2, wa;
      logic [31:0] wd;
      logic [2:0]  gnt;
   } vec_t;

   typedef struct {
      logic        port;
      logic [31:0] data;
   } sb_t;

   vec_t        tbl [24];
   vec_t        seq [5];
   sb_t         sb [$];
   logic [31:0] ref_mem [32];
   logic [31:0] hold1 = '0, hold2 = '0;
   int          errors = 0, checks = 0;

   function automatic vec_t mk(input logic r1, input logic r2, input logic w,
                               input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [2:0] gnt);
      vec_t v;
      v.r1 = r1; v.r2 = r2; v.w = w; v.a1 = a1; v.a2 = a2; v.wa = wa; v.wd = wd; v.gnt = gnt;
      return v;
   endfunction

   function automatic logic [31:0] refRead(input logic [4:0] a);
`ifdef REGFILE_X0_ZERO_EN
      if (a == 5'd0) return 32'd0;
`endif
      return ref_mem[a];
   endfunction

   function automatic logic refWe(input logic [4:0] a);
`ifdef REGFILE_X0_ZERO_EN
      return a != 5'd0;
`else
      return a == a;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // Drives one row, checks at the falling edge, then updates scoreboard and reference memory
   task automatic applyStimulus(input vec_t v, input string tag);
      sb_t         e;
      logic        ev1, ev2;
      logic [31:0] ed1, ed2;
      logic [4:0]  ea;
      rs1_req = v.r1; rs2_req = v.r2; wr_req = v.w;
      rs1_addr = v.a1; rs2_addr = v.a2; wr_addr = v.wa; wr_data = v.wd;
      @(negedge clk);
      checkOutput({tag, " gnt"}, {29'd0, wr_gnt, rs2_gnt, rs1_gnt}, {29'd0, v.gnt});
      checkOutput({tag, " we"}, {31'd0, sram_we}, {31'd0, v.gnt[2] && refWe(v.wa)});
      ea = v.gnt[2] ? v.wa : v.gnt[0] ? v.a1 : v.gnt[1] ? v.a2 : 5'd0;
      checkOutput({tag, " addr"}, {27'd0, sram_addr}, {27'd0, ea});
      if (v.gnt[2])       checkOutput({tag, " din"}, sram_din, v.wd);
      else if (v.gnt == 0) checkOutput({tag, " din"}, sram_din, 32'd0);
      ev1 = 1'b0; ev2 = 1'b0; ed1 = hold1; ed2 = hold2;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         if (e.port) begin ev2 = 1'b1; ed2 = e.data; end
         else        begin ev1 = 1'b1; ed1 = e.data; end
      end
      checkOutput({tag, " rs1_valid"}, {31'd0, rs1_valid}, {31'd0, ev1});
      checkOutput({tag, " rs2_valid"}, {31'd0, rs2_valid}, {31'd0, ev2});
      checkOutput({tag, " rs1_data"}, rs1_data, ed1);
      checkOutput({tag, " rs2_data"}, rs2_data, ed2);
      hold1 = ed1; hold2 = ed2;
      if (v.gnt[0]) begin e.port = 1'b0; e.data = refRead(v.a1); sb.push_back(e); end
      if (v.gnt[1]) begin e.port = 1'b1; e.data = refRead(v.a2); sb.push_back(e); end
      if (v.gnt[2] && refWe(v.wa)) ref_mem[v.wa] = v.wd;
   endtask

   initial begin
      tbl[0]  = mk(1, 0, 0,  3,  0,  0, 32'h0,        3'b001);
      tbl[1]  = mk(0, 0, 0,  0,  0,  0, 32'h0,        3'b000);
      tbl[2]  = mk(0, 0, 0,  0,  0,  0, 32'h0,        3'b000);
      tbl[3]  = mk(1, 1, 0,  7,  9,  0, 32'h0,        3'b010);
      tbl[4]  = mk(1, 1, 0,  7,  9,  0, 32'h0,        3'b001);
      tbl[5]  = mk(1, 1, 0,  7,  9,  0, 32'h0,        3'b010);
      tbl[6]  = mk(1, 1, 0,  7,  9,  0, 32'h0,        3'b001);
      tbl[7]  = mk(1, 0, 1, 13,  0, 10, 32'hA0A0_0000, 3'b100);
      tbl[8]  = mk(1, 0, 1, 13,  0, 11, 32'hA1A1_1111, 3'b100);
      tbl[9]  = mk(1, 0, 1, 13,  0, 12, 32'hA2A2_2222, 3'b100);
      tbl[10] = mk(1, 0, 1, 13,  0, 13, 32'hA3A3_3333, 3'b100);
      tbl[11] = mk(1, 0, 1, 13,  0, 14, 32'hA4A4_4444, 3'b001);
      tbl[12] = mk(0, 0, 1,  0,  0, 14, 32'hA4A4_4444, 3'b100);
      tbl[13] = mk(0, 1, 1,  0, 19, 16, 32'hB0B0_0000, 3'b100);
      tbl[14] = mk(0, 1, 1,  0, 19, 17, 32'hB1B1_1111, 3'b100);
      tbl[15] = mk(0, 1, 1,  0, 19, 18, 32'hB2B2_2222, 3'b100);
      tbl[16] = mk(0, 1, 1,  0, 19, 19, 32'hB3B3_3333, 3'b100);
      tbl[17] = mk(0, 1, 1,  0, 19, 20, 32'hB4B4_4444, 3'b010);
      tbl[18] = mk(0, 0, 1,  0,  0,  5, 32'h1234_5678, 3'b100);
      tbl[19] = mk(0, 1, 0,  0,  5,  0, 32'h0,        3'b010);
      tbl[20] = mk(0, 0, 1,  0,  0,  0, 32'hFFFF_FFFF, 3'b100);
      tbl[21] = mk(1, 0, 0,  0,  0,  0, 32'h0,        3'b001);
      tbl[22] = mk(0, 0, 0,  0,  0,  0, 32'h0,        3'b000);
      tbl[23] = mk(0, 0, 0,  0,  0,  0, 32'h0,        3'b000);
      seq[0]  = mk(1, 1, 0,  3,  5,  0, 32'h0,        3'b001);
      seq[1]  = mk(1, 1, 0,  3,  5,  0, 32'h0,        3'b010);
      seq[2]  = mk(1, 1, 0,  3,  5,  0, 32'h0,        3'b001);
      seq[3]  = mk(1, 1, 0,  3,  5,  0, 32'h0,        3'b010);
      seq[4]  = mk(0, 0, 0,  0,  0,  0, 32'h0,        3'b000);

      rst = 1'b1;
      rs1_req = 1'b1; rs2_req = 1'b1; wr_req = 1'b1;
      rs1_addr = 5'd1; rs2_addr = 5'd2; wr_addr = 5'd4; wr_data = 32'hCAFE_F00D;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         pre_we   = 1'b1;
         pre_addr = 5'(i);
         pre_data = (i == 3) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i) * 32'h0101;
         ref_mem[i] = pre_data;
      end
      @(negedge clk);
      pre_we = 1'b0;
      checkOutput("reset gnt", {29'd0, wr_gnt, rs2_gnt, rs1_gnt}, 32'd0);
      checkOutput("reset we", {31'd0, sram_we}, 32'd0);
      checkOutput("reset addr", {27'd0, sram_addr}, 32'd0);
      checkOutput("reset din", sram_din, 32'd0);
      checkOutput("reset valid", {30'd0, rs2_valid, rs1_valid}, 32'd0);
      checkOutput("reset rs1_data", rs1_data, 32'd0);
      checkOutput("reset rs2_data", rs2_data, 32'd0);
      #1 rst = 1'b0;
      rs1_req = 1'b0; rs2_req = 1'b0; wr_req = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 24; i++) begin
         applyStimulus(tbl[i], $sformatf("row%0d", i));
         @(posedge clk); #1;
      end

      // Reset lands while an rs1 read is in flight; its response must be dropped
      applyStimulus(mk(1, 0, 0, 3, 0, 0, 32'h0, 3'b001), "midrst grant");
      #1 rst = 1'b1;
      rs1_req = 1'b0; rs2_req = 1'b1; wr_req = 1'b1; wr_addr = 5'd6;
      #1;
      checkOutput("midrst gnt", {29'd0, wr_gnt, rs2_gnt, rs1_gnt}, 32'd0);
      checkOutput("midrst we", {31'd0, sram_we}, 32'd0);
      checkOutput("midrst addr", {27'd0, sram_addr}, 32'd0);
      checkOutput("midrst din", sram_din, 32'd0);
      @(negedge clk);
      checkOutput("midrst rs1_valid", {31'd0, rs1_valid}, 32'd0);
      checkOutput("midrst rs1_data", rs1_data, 32'd0);
      checkOutput("midrst rs2_data", rs2_data, 32'd0);
      sb.delete();
      hold1 = '0; hold2 = '0;
      #1 rst = 1'b0;
      rs2_req = 1'b0; wr_req = 1'b0;
      @(posedge clk); #1;
      checkOutput("postrst rs1_valid", {31'd0, rs1_valid}, 32'd0);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(seq[i], $sformatf("rr%0d", i));
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
